// File: rtl/instr_sequencer.sv
// instr_sequencer: loadable instruction RAM plus run-control FSM (IDLE/RUN/DONE/ERR) with stall, branch and optional nested hardware loops (macro SEQ_LOOP_EN); ports: CLK/RST, St start, load_* RAM write port, decoder controls (pc_src/jump_addr/halt/loop_*), outputs instruction/pc/enable/busy/done/err.
module instr_sequencer #(
  parameter int ADDR_BIT = 6,
  parameter int CNT_BIT = 8,
  parameter int LOOP_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                St,
  input  logic                jump,
  input  logic                stall,
  input  logic                load_en,
  input  logic [ADDR_BIT-1:0] load_addr,
  input  logic [31:0]         load_data,
  input  logic                pc_src,
  input  logic [ADDR_BIT-1:0] jump_addr,
  input  logic                halt,
  input  logic                loop_valid,
  input  logic [ADDR_BIT-1:0] loop_end,
  input  logic [CNT_BIT-1:0]  loop_count,
  output logic [31:0]         instruction,
  output logic [ADDR_BIT-1:0] pc,
  output logic                enable,
  output logic                busy,
  output logic                done,
  output logic                err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
  state_t state, nxt_state;
  logic [ADDR_BIT-1:0] nxt_pc, pc_inc;
  logic [31:0] mem [2**ADDR_BIT];
  logic clr, push, pop, dec, last;
  assign pc_inc = pc + 1'b1;
  assign last = &pc;
  assign instruction = mem[pc];
  assign busy = state == RUN;
  assign done = state == DONE;
  assign err = state == ERR;
  assign enable = busy & ~stall;
  always_ff @(posedge CLK)
    if (load_en && state != RUN) mem[load_addr] <= load_data;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      pc <= '0;
    end else begin
      state <= nxt_state;
      pc <= nxt_pc;
    end
`ifdef SEQ_LOOP_EN
  // Shift stack: entry 0 is always the innermost (top) loop.
  logic [LOOP_DEPTH-1:0] vld;
  logic [ADDR_BIT-1:0] s_start [LOOP_DEPTH];
  logic [ADDR_BIT-1:0] s_end [LOOP_DEPTH];
  logic [CNT_BIT-1:0] s_cnt [LOOP_DEPTH];
  always_ff @(posedge CLK or posedge RST)
    if (RST) vld <= '0;
    else if (clr) vld <= '0;
    else if (push) vld <= {vld[LOOP_DEPTH-2:0], 1'b1};
    else if (pop) vld <= vld >> 1;
  always_ff @(posedge CLK)
    if (push) begin
      for (int i = LOOP_DEPTH - 1; i > 0; i--) begin
        s_start[i] <= s_start[i-1];
        s_end[i] <= s_end[i-1];
        s_cnt[i] <= s_cnt[i-1];
      end
      s_start[0] <= pc_inc;
      s_end[0] <= loop_end;
      s_cnt[0] <= loop_count;
    end else if (pop) begin
      for (int i = 0; i < LOOP_DEPTH - 1; i++) begin
        s_start[i] <= s_start[i+1];
        s_end[i] <= s_end[i+1];
        s_cnt[i] <= s_cnt[i+1];
      end
    end else if (dec) s_cnt[0] <= s_cnt[0] - 1'b1;
`else
  logic unused_loop;
  localparam int unused_depth = LOOP_DEPTH;
  assign unused_loop = ^{loop_valid, loop_end, loop_count};
`endif
  always_comb begin
    nxt_state = state;
    nxt_pc = pc;
    clr = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    dec = 1'b0;
    if (state != RUN) begin
      if (St) begin
        nxt_state = RUN;
        nxt_pc = '0;
        clr = 1'b1;
      end
    end else if (!stall) begin
      if (halt) nxt_state = DONE;
      else if (pc_src && jump) nxt_pc = jump_addr;
`ifdef SEQ_LOOP_EN
      else if (vld[0] && pc == s_end[0]) begin
        if (s_cnt[0] > CNT_BIT'(1)) begin
          nxt_pc = s_start[0];
          dec = 1'b1;
        end else if (last) nxt_state = ERR;
        else begin
          pop = 1'b1;
          nxt_pc = pc_inc;
        end
      end else if (loop_valid) begin
        // A zero-count skip to the last address would wrap, so it is an error too.
        if (loop_end <= pc) nxt_state = ERR;
        else if (loop_count == '0) begin
          if (&loop_end) nxt_state = ERR;
          else nxt_pc = loop_end + 1'b1;
        end else if (vld[LOOP_DEPTH-1]) nxt_state = ERR;
        else begin
          push = 1'b1;
          nxt_pc = pc_inc;
        end
      end
`endif
      else if (last) nxt_state = ERR;
      else nxt_pc = pc_inc;
    end
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Parametrised fetch/sequencing unit for the matrix processor. It replaces the fixed-size, file-initialised instruction memory and the start/done controller with a loadable instruction RAM and a run-control FSM. It adds stall handling, an error state and (optionally) nested hardware loops. It sits between the bench/host load port and the instruction decoder, and supplies `instruction`, `pc` and the datapath `enable` qualifier.

## Interface
- `ADDR_BIT`, 6: PC/RAM address width; depth = 2**ADDR_BIT words.
- `CNT_BIT`, 8: loop iteration count width.
- `LOOP_DEPTH`, 4: loop stack entries; only used with `SEQ_LOOP_EN`.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `St` in 1: start request.
- `jump` in 1: global branch enable.
- `stall` in 1: datapath busy; hold PC.
- `load_en` in 1, `load_addr` in ADDR_BIT, `load_data` in 32: instruction RAM write port.
- `pc_src` in 1, `jump_addr` in ADDR_BIT: branch request and target, from the decoder.
- `halt` in 1: end-of-program, from the decoder.
- `loop_valid` in 1, `loop_end` in ADDR_BIT, `loop_count` in CNT_BIT: loop instruction fields, from the decoder.
- `instruction` out 32: RAM word at `pc`, combinational read.
- `pc` out ADDR_BIT: current PC.
- `enable` out 1: datapath write qualifier.
- `busy` out 1: FSM is in RUN.
- `done` out 1: FSM is in DONE.
- `err` out 1: FSM is in ERR.

## Operation
- FSM states are IDLE, RUN, DONE and ERR.
- Transitions:
  - IDLE/DONE/ERR + `St` -> RUN, with `pc`<=0 and the loop stack cleared.
  - RUN + `St` is ignored.
- RAM writes:
  - A write occurs when `load_en`=1 and the state is not RUN.
  - `load_en` during RUN is dropped.
  - RAM is not cleared by `RST`.
- In RUN with `stall`=1: `pc` and the loop stack hold, and `enable`=0.
- In RUN with `stall`=0, the next PC is chosen by this priority:
  1. `halt` -> DONE; `pc` holds.
  2. `pc_src & jump` -> `pc`<=`jump_addr`.
  3. Loop end: top of stack valid and `pc`==top.end.
     - If top.count>1: `pc`<=top.start and top.count decrements.
     - Otherwise: pop and `pc`<=`pc`+1.
  4. `loop_valid`:
     - If `loop_count`=0: `pc`<=`loop_end`+1 with no push.
     - Otherwise: push {start=`pc`+1, end=`loop_end`, count=`loop_count`} and `pc`<=`pc`+1.
  5. Otherwise `pc`<=`pc`+1.
- Error conditions, each going to ERR:
  - `pc`==2**ADDR_BIT-1 with no halt/jump/loop-end redirect (no wrap-around).
  - Push when the stack is full.
  - `loop_valid` with `loop_end`<=`pc`.
- In ERR and DONE: `pc` holds and `enable`=0.
- Output decode:
  - `enable` = (state==RUN) & ~`stall`.
  - `busy`, `done` and `err` are decoded from the state register; they are mutually exclusive.
- Arithmetic:
  - `pc`+1 and `loop_end`+1 are computed at ADDR_BIT width.
  - Overflow is caught by the ERR rule before it is used.

## Timing
- Reset values: state=IDLE, `pc`=0, stack empty, `enable`=0, `busy`=0, `done`=0, `err`=0. `instruction` shows RAM[0].
- `RST` mid-run: immediate return to IDLE with the stack cleared; RAM contents are retained.
- `St` is sampled at a rising edge. Instruction 0 is presented in the first RUN cycle, one cycle after `St`.
- One instruction per unstalled RUN cycle. Branch and loop redirects take effect at the next edge with no bubble.
- `done` rises the cycle after the edge that samples `halt`. It stays high until `St` or `RST`.
- `instruction` follows `pc` combinationally. A RAM write is visible on the cycle after its edge.
- Simultaneous `halt` and `pc_src`: halt wins.
- `stall` and `halt` together: halt is not taken until `stall`=0.

## Configuration
- `SEQ_LOOP_EN` defined: the loop stack and loop-end/push logic are built as described.
- `SEQ_LOOP_EN` undefined:
  - No stack is built; `loop_valid`, `loop_end` and `loop_count` are ignored, and rule 4 behaves as rule 5.
  - The stack-overflow and bad-`loop_end` ERR causes are absent.

## Test plan
- Load 4 words and pulse `St` with no control inputs, `halt` at pc 3 -> pc 0,1,2,3; `done`=1 from the next cycle; `enable`=0 while `done`.
- `pc_src`=1 at pc 2 with `jump_addr`=5: `jump`=1 -> pc 5; `jump`=0 -> pc 3.
- With `SEQ_LOOP_EN`: loop at pc 1 with count 3 and end 3, `halt` at 4 -> pc trace 0,1,2,3,2,3,2,3,4, then `done`. Repeat with count 0 -> trace 0,1,4.
- `stall` high for 2 cycles at pc 2 -> pc stays at 2 for 3 cycles total, `enable`=0 for those 2 cycles, then pc 3.
- Assert `RST` asynchronously at pc 3 -> immediate IDLE with pc 0 and `busy`=0. Pulse `St` again -> identical trace, proving RAM is retained.
- Five nested loops with `LOOP_DEPTH`=4 -> `err`=1 on the fifth push. Separately, run off the end at pc 63 (`ADDR_BIT`=6) -> `err`=1.
